// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: sample/twiddle widths and the
// butterfly scheduler state encoding.
package fft_pkg;

    localparam int SAMPLE_SIZE      = 16;
    localparam int TWIDDLE_SIZE     = 16;
    localparam int CALCULATION_SIZE = 2 * SAMPLE_SIZE;
    localparam int BUFFER_SIZE      = 1024;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        FIN
    } fft_sched_state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational radix-2 DIT address generator: maps (stage, butterfly) to the
// even/odd buffer addresses and the twiddle ROM index.
module fft_addr_gen #(
    parameter int LOG2_N = 10,
    parameter int ADDR_W = LOG2_N,
    parameter int TW_W   = (ADDR_W > 1) ? ADDR_W - 1 : 1
) (
    input  logic [LOG2_N-1:0] stage_i,
    input  logic [TW_W-1:0]   bfly_i,
    output logic [ADDR_W-1:0] even_o,
    output logic [ADDR_W-1:0] odd_o,
    output logic [TW_W-1:0]   tw_o
);

    logic [ADDR_W-1:0] j_w;
    logic [ADDR_W-1:0] half;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] even;
    logic [LOG2_N-1:0] s_p1;
    logic [LOG2_N-1:0] tw_sh;

    // Bit s of the even address is always 0, so OR-ing half equals adding it.
    always_comb begin
        j_w   = ADDR_W'(bfly_i);
        half  = ADDR_W'(1) << stage_i;
        k     = j_w & (half - ADDR_W'(1));
        s_p1  = stage_i + LOG2_N'(1);
        tw_sh = LOG2_N'(LOG2_N - 1) - stage_i;
        even  = ((j_w >> stage_i) << s_p1) | k;
    end

    assign even_o = even;
    assign odd_o  = even | half;
    assign tw_o   = TW_W'(k) << tw_sh;

endmodule

// File: rtl/fft_butterfly_scheduler.sv
// Sequences an in-place radix-2 DIT FFT through one shared butterfly unit:
// issue read, wait for done, write back, for every stage and butterfly.
module fft_butterfly_scheduler
    import fft_pkg::*;
#(
    parameter int  NUM_SAMPLES = 1024,
    parameter int  LOG2_N      = $clog2(NUM_SAMPLES),
    parameter int  ADDR_W      = LOG2_N,
    localparam int TW_W        = (ADDR_W > 1) ? ADDR_W - 1 : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              bfly_read,
    input  logic              bfly_done,
    output logic [ADDR_W-1:0] even_addr,
    output logic [ADDR_W-1:0] odd_addr,
    output logic [TW_W-1:0]   twiddle_index,
    output logic              wr_en,
    output logic [LOG2_N-1:0] stage,
    output logic              busy,
    output logic              done
);

    localparam logic [TW_W-1:0]   J_LAST = TW_W'(NUM_SAMPLES / 2 - 1);
    localparam logic [LOG2_N-1:0] S_LAST = LOG2_N'(LOG2_N - 1);

    fft_sched_state_t  state_q, state_d;
    logic [LOG2_N-1:0] stage_q, stage_d;
    logic [TW_W-1:0]   bfly_q, bfly_d;
    logic [ADDR_W-1:0] even_q, odd_q, even_c, odd_c;
    logic [TW_W-1:0]   tw_q, tw_c;
    logic              load;
    logic              abort_hit;

    // Addresses are computed from the next (stage, butterfly) so they are
    // already valid in the ISSUE cycle and hold through WRITE.
    fft_addr_gen #(
        .LOG2_N (LOG2_N),
        .ADDR_W (ADDR_W),
        .TW_W   (TW_W)
    ) u_addr_gen (
        .stage_i (stage_d),
        .bfly_i  (bfly_d),
        .even_o  (even_c),
        .odd_o   (odd_c),
        .tw_o    (tw_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            bfly_q  <= '0;
            even_q  <= '0;
            odd_q   <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            if (load) begin
                even_q <= even_c;
                odd_q  <= odd_c;
                tw_q   <= tw_c;
            end
        end
    end

    assign abort_hit = abort && (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        bfly_d    = bfly_q;
        load      = 1'b0;
        bfly_read = 1'b0;
        wr_en     = 1'b0;
        done      = 1'b0;
        if (abort_hit) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = ISSUE;
                        stage_d = '0;
                        bfly_d  = '0;
                        load    = 1'b1;
                    end
                end
                ISSUE: begin
                    bfly_read = 1'b1;
                    state_d   = WAIT;
                end
                WAIT: begin
                    if (bfly_done) begin
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    wr_en = 1'b1;
                    if (bfly_q == J_LAST && stage_q == S_LAST) begin
                        state_d = FIN;
                    end else if (bfly_q == J_LAST) begin
                        bfly_d  = '0;
                        stage_d = stage_q + LOG2_N'(1);
                        state_d = ISSUE;
                        load    = 1'b1;
                    end else begin
                        bfly_d  = bfly_q + TW_W'(1);
                        state_d = ISSUE;
                        load    = 1'b1;
                    end
                end
                FIN: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign busy          = (state_q != IDLE);
    assign even_addr     = even_q;
    assign odd_addr      = odd_q;
    assign twiddle_index = tw_q;
    assign stage         = stage_q;

endmodule
